// File: rtl/dsdmnist_pkg.sv
// Shared types and constants for the dsdmnist result read-back path.
package dsdmnist_pkg;

    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} resultreader_state_t;

    typedef logic signed [31:0] score_t;

endpackage

// File: rtl/dsdmnist_argmax10.sv
// Running signed argmax over the ten class scores of one image.
// The max_score port exists only when DSDMNIST_RESULTREADER_SCORE_EN is defined.
module dsdmnist_argmax10
    import dsdmnist_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       first,
    input  logic       data_valid,
    input  score_t     data,
    input  logic [3:0] k,
`ifdef DSDMNIST_RESULTREADER_SCORE_EN
    output score_t     max_score,
`endif
    output logic [3:0] digit
);

    score_t max_q;

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (clear) begin
            max_q <= '0;
            digit <= '0;
        end else if (data_valid) begin
            if (first || (data > max_q)) begin
                max_q <= data;
                digit <= k;
            end
        end
    end

`ifdef DSDMNIST_RESULTREADER_SCORE_EN
    assign max_score = max_q;
`endif

endmodule

// File: rtl/dsdmnist_resultreader.sv
// Reads IMGNUM groups of ten scores from the result buffer and streams one argmax per image.
// Define DSDMNIST_RESULTREADER_SCORE_EN to add the o_CLASS_SCORE output.
module dsdmnist_resultreader
    import dsdmnist_pkg::*;
#(
    parameter int IMGNUM = 10,
    parameter int OAW    = $clog2(IMGNUM * 10),
    parameter int NAW    = (IMGNUM > 1) ? $clog2(IMGNUM) : 1
) (
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_START,
    output logic            o_BUSY,
    output logic            o_DONE,
    output logic            o_RESULTBUF_EN,
    output logic [OAW-1:0]  o_RESULTBUF_ADDR,
    input  logic [31:0]     i_RESULTBUF_DATA,
    output logic            o_CLASS_VALID,
    input  logic            i_CLASS_READY,
    output logic [3:0]      o_CLASS_DIGIT,
`ifdef DSDMNIST_RESULTREADER_SCORE_EN
    output logic [31:0]     o_CLASS_SCORE,
`endif
    output logic [NAW-1:0]  o_CLASS_IDX
);

    localparam logic [3:0]     LAST_K   = 4'(NUM_CLASSES - 1);
    localparam logic [NAW-1:0] LAST_IMG = NAW'(IMGNUM - 1);
    localparam logic [OAW-1:0] STEP     = OAW'(NUM_CLASSES);

    resultreader_state_t state;
    logic [3:0]          k;
    logic [NAW-1:0]      img;
    logic [OAW-1:0]      base;
    logic                rd_valid;
    logic [3:0]          rd_k;

    // rd_valid/rd_k trail EN by one cycle to line up with the buffer's read latency.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state            <= IDLE;
            k                <= '0;
            img              <= '0;
            base             <= '0;
            rd_valid         <= 1'b0;
            rd_k             <= '0;
            o_BUSY           <= 1'b0;
            o_DONE           <= 1'b0;
            o_RESULTBUF_EN   <= 1'b0;
            o_RESULTBUF_ADDR <= '0;
            o_CLASS_VALID    <= 1'b0;
        end else begin
            o_DONE   <= 1'b0;
            rd_valid <= o_RESULTBUF_EN;
            rd_k     <= k;
            case (state)
                IDLE: begin
                    if (i_START) begin
                        state            <= READ;
                        img              <= '0;
                        k                <= '0;
                        base             <= '0;
                        o_RESULTBUF_ADDR <= '0;
                        o_RESULTBUF_EN   <= 1'b1;
                        o_BUSY           <= 1'b1;
                    end
                end
                READ: begin
                    if (k == LAST_K) begin
                        state          <= DRAIN;
                        o_RESULTBUF_EN <= 1'b0;
                    end else begin
                        k                <= k + 4'd1;
                        o_RESULTBUF_ADDR <= o_RESULTBUF_ADDR + OAW'(1);
                    end
                end
                DRAIN: begin
                    state         <= EMIT;
                    o_CLASS_VALID <= 1'b1;
                end
                EMIT: begin
                    if (i_CLASS_READY) begin
                        o_CLASS_VALID <= 1'b0;
                        if (img == LAST_IMG) begin
                            state  <= IDLE;
                            o_BUSY <= 1'b0;
                            o_DONE <= 1'b1;
                        end else begin
                            state            <= READ;
                            img              <= img + NAW'(1);
                            k                <= '0;
                            base             <= base + STEP;
                            o_RESULTBUF_ADDR <= base + STEP;
                            o_RESULTBUF_EN   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DSDMNIST_RESULTREADER_SCORE_EN
    score_t max_score;
`endif

    dsdmnist_argmax10 u_argmax (
        .clk        (i_CLK),
        .clear      (i_RST),
        .first      (rd_k == 4'd0),
        .data_valid (rd_valid),
        .data       (score_t'(i_RESULTBUF_DATA)),
        .k          (rd_k),
`ifdef DSDMNIST_RESULTREADER_SCORE_EN
        .max_score  (max_score),
`endif
        .digit      (o_CLASS_DIGIT)
    );

`ifdef DSDMNIST_RESULTREADER_SCORE_EN
    assign o_CLASS_SCORE = max_score;
`endif

    assign o_CLASS_IDX = img;

endmodule
